// File: rtl/pipo_ctrl_pkg.sv
// Shared types and constants for the PIPO load arbiter.
package pipo_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin loader of one shared holding register with a post-load hold window.
//   state | meaning
//   IDLE  | waiting for an unfrozen request; loads the winner's word
//   HOLD  | hold window after a load; requests ignored until counter expires
module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2,
  localparam int OWNER_W = owner_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   freeze,
  output logic [WIDTH-1:0]       q,
  output logic [N_REQ-1:0]       gnt,
  output logic [OWNER_W-1:0]     owner,
  output logic                   valid,
  output logic                   busy
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OWNER_W-1:0] ptr, ptr_n;
  logic [WIDTH-1:0]   q_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [OWNER_W-1:0] owner_n;
  logic               valid_n, busy_n;

  logic [N_REQ-1:0]   win_onehot;
  logic [OWNER_W-1:0] win_idx;
  logic               win_any;
  logic [WIDTH-1:0]   win_word;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (OWNER_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign win_word = data_in[int'(win_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    q_n     = q;
    gnt_n   = '0;
    owner_n = owner;
    valid_n = valid;
    busy_n  = busy;
    case (state)
      IDLE: begin
        if (win_any && !freeze) begin
          q_n     = win_word;
          gnt_n   = win_onehot;
          owner_n = win_idx;
          valid_n = 1'b1;
          ptr_n   = (win_idx == OWNER_W'(N_REQ-1)) ? '0 : win_idx + OWNER_W'(1);
          // With no hold window the block stays in IDLE and can load every cycle.
          if (HOLD_CYC > 0) begin
            state_n = HOLD;
            cnt_n   = CNT_W'(HOLD_CYC);
            busy_n  = 1'b1;
          end
        end
      end
      HOLD: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      q     <= '0;
      gnt   <= '0;
      owner <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      q     <= q_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      valid <= valid_n;
      busy  <= busy_n;
    end
  end

endmodule
